// File: rtl/branch_resolver.sv
// Execute-side branch resolver: queues in-flight predictions from fetch, checks them
// against EX outcomes, drives predictor updates, mispredict flush/redirect and statistics.
module branch_resolver #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             if_push,
   input  logic [31:0]      if_pc,
   input  logic             if_pred_taken,
   input  logic [31:0]      if_pred_target,
   output logic             q_full,
   input  logic             ex_valid,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   input  logic             ext_flush,
   output logic             upd_valid,
   output logic [31:0]      upd_pc,
   output logic             upd_taken,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mp_count,
   output logic             err_overflow,
   output logic             err_underflow
);

   localparam int unsigned PC_W  = 32;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_target;
   } entry_t;

   entry_t            mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;

   logic              upd_valid_q, upd_valid_d;
   logic [PC_W-1:0]   upd_pc_q, upd_pc_d;
   logic              upd_taken_q, upd_taken_d;
   logic              mispredict_q, mispredict_d;
   logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0]  br_count_q, br_count_d;
   logic [CNT_W-1:0]  mp_count_q, mp_count_d;
   logic              err_ov_q, err_ov_d;
   logic              err_un_q, err_un_d;

   logic              full_c, empty_c, pop_c, push_c, mp_c;
   entry_t            head_c;

   // Queue control, resolution and next-state of every register
   always_comb begin
      full_c        = (occ_q == OCC_W'(DEPTH));
      empty_c       = (occ_q == '0);
      head_c        = empty_c ? '0 : mem_q[rd_ptr_q];
      pop_c         = ex_valid && !empty_c;
      mp_c          = ex_valid && ((ex_taken != head_c.pred_taken) ||
                                   (ex_taken && (ex_target != head_c.pred_target)));
      // A mispredict or external flush means anything fetched this cycle is wrong-path
      push_c        = if_push && !mp_c && !ext_flush && (!full_c || pop_c);

      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      occ_d         = occ_q;
      upd_valid_d   = ex_valid;
      upd_pc_d      = upd_pc_q;
      upd_taken_d   = upd_taken_q;
      mispredict_d  = mp_c;
      redirect_pc_d = redirect_pc_q;
      br_count_d    = br_count_q;
      mp_count_d    = mp_count_q;
      err_ov_d      = err_ov_q | (if_push && full_c && !ex_valid);
      err_un_d      = err_un_q | (ex_valid && empty_c);

      if (mp_c || ext_flush) begin
         rd_ptr_d = wr_ptr_q;
         occ_d    = '0;
      end else begin
         if (pop_c)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
         if (push_c) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
         occ_d = OCC_W'(occ_q + OCC_W'(push_c) - OCC_W'(pop_c));
      end

      if (ex_valid) begin
         upd_pc_d      = head_c.pc;
         upd_taken_d   = ex_taken;
         redirect_pc_d = ex_taken ? ex_target : PC_W'(head_c.pc + PC_W'(4));
         if (br_count_q != '1) br_count_d = CNT_W'(br_count_q + CNT_W'(1));
      end
      if (mp_c && (mp_count_q != '1)) mp_count_d = CNT_W'(mp_count_q + CNT_W'(1));
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         occ_q         <= '0;
         upd_valid_q   <= 1'b0;
         upd_pc_q      <= '0;
         upd_taken_q   <= 1'b0;
         mispredict_q  <= 1'b0;
         redirect_pc_q <= '0;
         br_count_q    <= '0;
         mp_count_q    <= '0;
         err_ov_q      <= 1'b0;
         err_un_q      <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         occ_q         <= occ_d;
         upd_valid_q   <= upd_valid_d;
         upd_pc_q      <= upd_pc_d;
         upd_taken_q   <= upd_taken_d;
         mispredict_q  <= mispredict_d;
         redirect_pc_q <= redirect_pc_d;
         br_count_q    <= br_count_d;
         mp_count_q    <= mp_count_d;
         err_ov_q      <= err_ov_d;
         err_un_q      <= err_un_d;
      end
   end

   // Payload storage needs no reset; empty slots are never read
   always_ff @(posedge clk) begin
      if (rstn && push_c) begin
         mem_q[wr_ptr_q] <= '{pc: if_pc, pred_taken: if_pred_taken, pred_target: if_pred_target};
      end
   end

   assign q_full        = full_c;
   assign upd_valid     = upd_valid_q;
   assign upd_pc        = upd_pc_q;
   assign upd_taken     = upd_taken_q;
   assign mispredict    = mispredict_q;
   assign redirect_pc   = redirect_pc_q;
   assign br_count      = br_count_q;
   assign mp_count      = mp_count_q;
   assign err_overflow  = err_ov_q;
   assign err_underflow = err_un_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_branch_resolver;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rstn, if_push, if_pred_taken, ex_valid, ex_taken, ext_flush;
   logic [31:0]      if_pc, if_pred_target, ex_target;
   logic             q_full, upd_valid, upd_taken, mispredict, err_overflow, err_underflow;
   logic [31:0]      upd_pc, redirect_pc;
   logic [CNT_W-1:0] br_count, mp_count;

   branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .if_push(if_push), .if_pc(if_pc),
      .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target), .q_full(q_full),
      .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target), .ext_flush(ext_flush),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count),
      .err_overflow(err_overflow), .err_underflow(err_underflow));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tgt;
   } ent_t;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic        mp;
      logic [31:0] redir;
   } exp_t;

   ent_t mq[$];
   exp_t sb[$];
   int   m_br, m_mp;
   bit   m_ov, m_un;
   int   checks = 0;
   int   passes = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // One clock: check registered state, drive inputs, advance the reference model
   task automatic cyc(input bit rst_n, input bit push, input logic [31:0] pc, input bit pt,
                      input logic [31:0] ptgt, input bit exv, input bit tk,
                      input logic [31:0] tgt, input bit fl);
      ent_t h;
      bit   empty, full, mp;
      @(negedge clk);
      chk("q_full", 32'(q_full), 32'(mq.size() == DEPTH));
      chk("br_count", 32'(br_count), 32'(m_br));
      chk("mp_count", 32'(mp_count), 32'(m_mp));
      chk("err_overflow", 32'(err_overflow), 32'(m_ov));
      chk("err_underflow", 32'(err_underflow), 32'(m_un));
      rstn = rst_n; if_push = push; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt;
      ex_valid = exv; ex_taken = tk; ex_target = tgt; ext_flush = fl;
      if (!rst_n) begin
         mq.delete(); m_br = 0; m_mp = 0; m_ov = 0; m_un = 0;
      end else begin
         empty = (mq.size() == 0);
         full  = (mq.size() == DEPTH);
         mp    = 1'b0;
         h.pc = 32'h0; h.pt = 1'b0; h.tgt = 32'h0;
         if (!empty) h = mq[0];
         if (exv) begin
            mp = (tk != h.pt) || (tk && tgt != h.tgt);
            if (empty) m_un = 1;
            if (m_br < CMAX) m_br++;
            if (mp && m_mp < CMAX) m_mp++;
            sb.push_back('{pc: h.pc, taken: tk, mp: mp, redir: tk ? tgt : h.pc + 32'd4});
            if (!empty) void'(mq.pop_front());
         end
         if (push && full && !exv) m_ov = 1;
         if (mp || fl) mq.delete();
         else if (push && (!full || exv)) mq.push_back('{pc: pc, pt: pt, tgt: ptgt});
      end
   endtask

   task automatic idle();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic push1(input logic [31:0] pc, input bit pt, input logic [31:0] ptgt);
      cyc(1, 1, pc, pt, ptgt, 0, 0, 0, 0);
   endtask
   task automatic resolve(input bit tk, input logic [31:0] tgt);
      cyc(1, 0, 0, 0, 0, 1, tk, tgt, 0);
   endtask

   task automatic check_reset_outputs();
      @(posedge clk); #1;
      chk("rst_upd_valid", 32'(upd_valid), 32'h0);
      chk("rst_mispredict", 32'(mispredict), 32'h0);
      chk("rst_upd_pc", upd_pc, 32'h0);
      chk("rst_upd_taken", 32'(upd_taken), 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
   endtask

   // Monitor: every update pulse is matched against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (upd_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_upd_valid", 32'(upd_valid), 32'h0);
            end else begin
               e = sb.pop_front();
               chk("upd_pc", upd_pc, e.pc);
               chk("upd_taken", 32'(upd_taken), 32'(e.taken));
               chk("mispredict", 32'(mispredict), 32'(e.mp));
               if (e.mp) chk("redirect_pc", redirect_pc, e.redir);
            end
         end else begin
            chk("mispredict_without_upd", 32'(mispredict), 32'h0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 0; if_push = 0; if_pc = 0; if_pred_taken = 0; if_pred_target = 0;
      ex_valid = 0; ex_taken = 0; ex_target = 0; ext_flush = 0;
      m_br = 0; m_mp = 0; m_ov = 0; m_un = 0;
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_reset_outputs();
      idle();

      // Correct not-taken prediction
      push1(32'h100, 0, 0);
      resolve(0, 0);
      idle();
      // Not-taken predicted, taken actual: flush of younger entries
      push1(32'h200, 0, 0); push1(32'h204, 0, 0); push1(32'h208, 0, 0);
      resolve(1, 32'h300);
      idle(); idle();
      // Wrong target, then taken->not-taken, then PC wrap on redirect
      push1(32'h400, 1, 32'h500); resolve(1, 32'h504);
      push1(32'h600, 1, 32'h700); resolve(0, 0);
      push1(32'hFFFF_FFFC, 1, 32'h10); resolve(0, 0);
      idle();
      // Fill, overflow, push+pop while full across the pointer wrap
      for (int i = 0; i < 4; i++) push1(32'h1000 + 32'(i * 4), 0, 0);
      push1(32'h1FF0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 32'h2000 + 32'(i * 4), 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) resolve(0, 0);
      idle();
      // Underflow
      resolve(1, 32'h40);
      idle();
      // External flush with a correct resolution and a concurrent push
      push1(32'h800, 0, 0); push1(32'h804, 0, 0);
      cyc(1, 1, 32'h900, 0, 0, 1, 0, 0, 1);
      resolve(0, 0);
      idle();
      // Reset while an update is pending
      push1(32'hA00, 0, 0);
      cyc(0, 1, 32'hA04, 0, 0, 1, 1, 32'h50, 0);
      check_reset_outputs();

      // Random traffic; small counters also exercise saturation
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1,
             $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1,
             ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80,
             $urandom_range(0, 15) == 0);
      end
      idle(); idle(); idle();
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
